// File: rtl/uram_update_apply_pkg.sv
// Shared widths and the vertex-update record used by the apply stage and the
// update-shuffle stage that feeds it.
package uram_update_apply_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int CNT_W_DEF  = 16;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] val;
        logic                  last;
    } vtx_upd_t;

endpackage

// File: rtl/uram_fwd_min.sv
// Combinational merge for the apply stage: picks the freshest stored value
// (forwarded or URAM) and flags a write when the candidate improves it by min.
module uram_fwd_min #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              i_fwd_valid,
    input  logic [ADDR_W-1:0] i_fwd_addr,
    input  logic [DATA_W-1:0] i_fwd_data,
    input  logic [ADDR_W-1:0] i_cand_addr,
    input  logic [DATA_W-1:0] i_cand_val,
    input  logic [DATA_W-1:0] i_ram_data,
    output logic [DATA_W-1:0] o_old,
    output logic              o_better
);

    logic w_hit;

    // The one-back write is not yet visible in the URAM read data.
    assign w_hit    = i_fwd_valid & (i_fwd_addr == i_cand_addr);
    assign o_old    = w_hit ? i_fwd_data : i_ram_data;
    assign o_better = (i_cand_val < o_old);

endmodule

// File: rtl/uram_update_apply.sv
// Apply-phase URAM client: reads each vertex, merges the update by min and
// writes back only on improvement, sustaining one update per cycle.
module uram_update_apply
    import uram_update_apply_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_val,
    input  logic              upd_last,
    output logic [DATA_W-1:0] ram_data_in,
    output logic [ADDR_W-1:0] ram_r_addr,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic              ram_w_en,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              done,
    output logic [CNT_W-1:0]  changed_cnt,
    output logic [CNT_W-1:0]  upd_cnt
);

    logic              w_acc;
    logic              w_wr;
    logic              w_better;
    logic [DATA_W-1:0] w_old;

    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [DATA_W-1:0] r_s1_val;
    logic              r_s1_last;
    logic              r_fwd_valid;
    logic [ADDR_W-1:0] r_fwd_addr;
    logic [DATA_W-1:0] r_fwd_data;
    logic              r_done;
    logic [CNT_W-1:0]  r_upd_cnt;
    logic [CNT_W-1:0]  r_chg_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        logic [CNT_W-1:0] res;
        res = v;
        if (inc && (v != {CNT_W{1'b1}})) begin
            res = v + CNT_W'(1);
        end else begin
            res = v;
        end
        return res;
    endfunction

    assign upd_ready = enable & rst_n;
    assign w_acc     = upd_valid & upd_ready;

    uram_fwd_min #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_min (
        .i_fwd_valid (r_fwd_valid),
        .i_fwd_addr  (r_fwd_addr),
        .i_fwd_data  (r_fwd_data),
        .i_cand_addr (r_s1_addr),
        .i_cand_val  (r_s1_val),
        .i_ram_data  (ram_data_out),
        .o_old       (w_old),
        .o_better    (w_better)
    );

    // A reset arriving while stage 1 is full must squash its write.
    assign w_wr = rst_n & r_s1_valid & w_better;

    // URAM control; addresses and data are held at zero while in reset.
    always_comb begin
        ram_r_addr  = {ADDR_W{1'b0}};
        ram_w_addr  = {ADDR_W{1'b0}};
        ram_data_in = {DATA_W{1'b0}};
        ram_w_en    = w_wr;
        ram_en      = w_acc | w_wr;
        if (rst_n) begin
            ram_r_addr  = upd_addr;
            ram_w_addr  = r_s1_addr;
            ram_data_in = r_s1_val;
        end else begin
            ram_r_addr  = {ADDR_W{1'b0}};
            ram_w_addr  = {ADDR_W{1'b0}};
            ram_data_in = {DATA_W{1'b0}};
        end
    end

    // Pipeline, forwarding register, done pulse and phase counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_addr   <= {ADDR_W{1'b0}};
            r_s1_val    <= {DATA_W{1'b0}};
            r_s1_last   <= 1'b0;
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= {ADDR_W{1'b0}};
            r_fwd_data  <= {DATA_W{1'b0}};
            r_done      <= 1'b0;
            r_upd_cnt   <= {CNT_W{1'b0}};
            r_chg_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_s1_valid  <= w_acc;
            r_s1_addr   <= upd_addr;
            r_s1_val    <= upd_val;
            r_s1_last   <= upd_last & w_acc;
            r_fwd_valid <= w_wr;
            r_fwd_addr  <= r_s1_addr;
            r_fwd_data  <= r_s1_val;
            r_done      <= r_s1_valid & r_s1_last;
            if (r_done) begin
                r_upd_cnt <= {CNT_W{1'b0}};
                r_chg_cnt <= {CNT_W{1'b0}};
            end else begin
                r_upd_cnt <= sat_inc(r_upd_cnt, w_acc);
                r_chg_cnt <= sat_inc(r_chg_cnt, w_wr);
            end
        end
    end

    assign done        = r_done;
    assign upd_cnt     = r_upd_cnt;
    assign changed_cnt = r_chg_cnt;

endmodule

// File: tb/tb_uram_update_apply.sv
// Directed bench for uram_update_apply with a behavioural read-before-write
// URAM; expected values are hand-computed per scenario.
module tb_uram_update_apply;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_addr;
    logic [DW-1:0] upd_val;
    logic          upd_last;
    logic [DW-1:0] ram_data_in;
    logic [AW-1:0] ram_r_addr;
    logic [AW-1:0] ram_w_addr;
    logic          ram_w_en;
    logic          ram_en;
    logic [DW-1:0] ram_data_out;
    logic          done;
    logic [CW-1:0] changed_cnt;
    logic [CW-1:0] upd_cnt;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    int            wen_seen;
    int            wen_base;

    int n_tests;
    int n_fail;

    uram_update_apply #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_addr     (upd_addr),
        .upd_val      (upd_val),
        .upd_last     (upd_last),
        .ram_data_in  (ram_data_in),
        .ram_r_addr   (ram_r_addr),
        .ram_w_addr   (ram_w_addr),
        .ram_w_en     (ram_w_en),
        .ram_en       (ram_en),
        .ram_data_out (ram_data_out),
        .done         (done),
        .changed_cnt  (changed_cnt),
        .upd_cnt      (upd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // URAM model: read returns the pre-write contents; bench preload port.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
        if (ram_en) begin
            if (ram_w_en) mem[ram_w_addr] <= ram_data_in;
            ram_data_out <= mem[ram_r_addr];
        end
    end

    initial wen_seen = 0;
    always @(posedge clk) begin
        if (ram_w_en) wen_seen <= wen_seen + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] v, input logic l);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_val   = v;
        upd_last  = l;
        #1;
    endtask

    task automatic idle();
        upd_valid = 1'b0;
        upd_addr  = '0;
        upd_val   = '0;
        upd_last  = 1'b0;
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; enable = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        ram_data_out = '0;
        idle();
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        step(); step();
        preload(10'd5, 32'd100);
        preload(10'd7, 32'hFFFF_FFFF);
        preload(10'd3, 32'hFFFF_FFFF);
        preload(10'd4, 32'hFFFF_FFFF);
        preload(10'd9, 32'd20);
        preload(10'd11, 32'hFFFF_FFFF);
        preload(10'd12, 32'hFFFF_FFFF);
        preload(10'd2, 32'd9);
        #1;
        check_eq("rst_ready", upd_ready, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_upd_cnt", upd_cnt, 0);
        check_eq("rst_chg_cnt", changed_cnt, 0);
        check_eq("rst_ram_en", ram_en, 0);

        rst_n = 1'b1; enable = 1'b1;

        // Single improving update with last.
        step(); send(10'd5, 32'd40, 1'b1);
        check_eq("t1_ready", upd_ready, 1);
        check_eq("t1_raddr", ram_r_addr, 5);
        check_eq("t1_en", ram_en, 1);
        step(); idle();
        check_eq("t1_wen", ram_w_en, 1);
        check_eq("t1_waddr", ram_w_addr, 5);
        check_eq("t1_wdata", ram_data_in, 40);
        check_eq("t1_upd_cnt_t1", upd_cnt, 1);
        step(); idle();
        check_eq("t1_done", done, 1);
        check_eq("t1_chg_cnt", changed_cnt, 1);
        check_eq("t1_upd_cnt", upd_cnt, 1);
        check_eq("t1_mem5", mem[5], 40);
        step(); idle();
        check_eq("t1_done_pulse", done, 0);
        check_eq("t1_cnt_clear", upd_cnt, 0);

        // Back-to-back same address, forwarded third compare.
        step(); send(10'd7, 32'd50, 1'b0);
        step(); send(10'd7, 32'd30, 1'b0);
        check_eq("t2_w1_en", ram_w_en, 1);
        check_eq("t2_w1_data", ram_data_in, 50);
        step(); send(10'd7, 32'd45, 1'b1);
        check_eq("t2_w2_en", ram_w_en, 1);
        check_eq("t2_w2_data", ram_data_in, 30);
        step(); idle();
        check_eq("t2_w3_en", ram_w_en, 0);
        step(); idle();
        check_eq("t2_done", done, 1);
        check_eq("t2_chg_cnt", changed_cnt, 2);
        check_eq("t2_upd_cnt", upd_cnt, 3);
        check_eq("t2_mem7", mem[7], 30);

        // Alternating addresses, distance-two read comes from the URAM.
        step(); send(10'd3, 32'd10, 1'b0);
        step(); send(10'd4, 32'd10, 1'b0);
        check_eq("t3_w1_addr", ram_w_addr, 3);
        step(); send(10'd3, 32'd5, 1'b1);
        check_eq("t3_w2_addr", ram_w_addr, 4);
        check_eq("t3_w2_en", ram_w_en, 1);
        step(); idle();
        check_eq("t3_w3_en", ram_w_en, 1);
        check_eq("t3_w3_addr", ram_w_addr, 3);
        check_eq("t3_w3_data", ram_data_in, 5);
        step(); idle();
        check_eq("t3_chg_cnt", changed_cnt, 3);
        check_eq("t3_mem3", mem[3], 5);
        check_eq("t3_mem4", mem[4], 10);

        // Equal value: no write.
        step(); idle();
        wen_base = wen_seen;
        step(); send(10'd9, 32'd20, 1'b1);
        step(); idle();
        check_eq("t4_wen", ram_w_en, 0);
        step(); idle();
        check_eq("t4_done", done, 1);
        check_eq("t4_chg_cnt", changed_cnt, 0);
        check_eq("t4_upd_cnt", upd_cnt, 1);
        check_eq("t4_wen_seen", 32'(wen_seen - wen_base), 0);
        check_eq("t4_mem9", mem[9], 20);

        // Enable dropped mid-stream with valid held high.
        step(); idle();
        step(); send(10'd11, 32'd7, 1'b0);
        step(); enable = 1'b0; send(10'd12, 32'd6, 1'b1);
        check_eq("t5_ready_low", upd_ready, 0);
        check_eq("t5_inflight_en", ram_w_en, 1);
        check_eq("t5_inflight_addr", ram_w_addr, 11);
        check_eq("t5_cnt_a", upd_cnt, 1);
        step(); send(10'd12, 32'd6, 1'b1);
        check_eq("t5_cnt_b", upd_cnt, 1);
        step(); send(10'd12, 32'd6, 1'b1);
        check_eq("t5_cnt_c", upd_cnt, 1);
        check_eq("t5_no_en", ram_en, 0);
        step(); enable = 1'b1; send(10'd12, 32'd6, 1'b1);
        check_eq("t5_ready_back", upd_ready, 1);
        step(); idle();
        check_eq("t5_w_addr", ram_w_addr, 12);
        check_eq("t5_w_data", ram_data_in, 6);
        step(); idle();
        check_eq("t5_done", done, 1);
        check_eq("t5_upd_cnt", upd_cnt, 2);
        check_eq("t5_chg_cnt", changed_cnt, 2);
        check_eq("t5_mem11", mem[11], 7);
        check_eq("t5_mem12", mem[12], 6);

        // Reset right after accept squashes the pending write.
        step(); idle();
        step(); send(10'd2, 32'd1, 1'b0);
        step(); rst_n = 1'b0; idle();
        check_eq("t6_wen_squash", ram_w_en, 0);
        check_eq("t6_en_squash", ram_en, 0);
        step(); idle();
        check_eq("t6_mem2", mem[2], 9);
        check_eq("t6_ready", upd_ready, 0);
        check_eq("t6_done", done, 0);
        check_eq("t6_upd_cnt", upd_cnt, 0);
        check_eq("t6_chg_cnt", changed_cnt, 0);
        check_eq("t6_waddr", ram_w_addr, 0);
        check_eq("t6_wdata", ram_data_in, 0);
        check_eq("t6_raddr", ram_r_addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
